johnson_phase_multiplier: RTL and testbench

- Sequential 4x4 unsigned shift-add multiplier whose micro-steps are driven by the eight one-hot timing phases T[7:0] produced by the 4-bit Johnson counter/decoder stage upstream.
- Each phase selects one micro-operation, so one multiply occupies exactly one Johnson revolution.
- Also supervises the phase stream. Non-one-hot or out-of-order phases abort the operation and raise a sticky error.

---
 rtl/johnson_phase_multiplier_if.sv | 22 ++
 rtl/johnson_phase_multiplier.sv | 88 ++++++++
 tb/tb_johnson_phase_multiplier.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/johnson_phase_multiplier_if.sv
// Phase, operand and result signals between the Johnson phase source and the shift-add multiplier.
interface johnson_phase_multiplier_if;
    logic [7:0] T;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       clr_err;
    logic [7:0] p;
    logic       busy;
    logic       done;
    logic       phase_err;

    modport master (
        output T, start, a, b, clr_err,
        input  p, busy, done, phase_err
    );

    modport slave (
        input  T, start, a, b, clr_err,
        output p, busy, done, phase_err
    );
endinterface

// File: rtl/johnson_phase_multiplier.sv
// 4x4 unsigned shift-add multiplier stepped by one-hot Johnson phases; T[0] load to p/done is 5 clocks.
// No backpressure: one multiply per phase revolution, bad phases abort and set a sticky error.
module johnson_phase_multiplier #(
    parameter bit CHECK_ORDER = 1'b1
) (
    input  logic clk,
    input  logic reset,
    johnson_phase_multiplier_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0] state;
    logic [7:0] prev_t;
    logic [4:0] acc;
    logic [3:0] mcand;
    logic [3:0] mplier;
    logic [7:0] p_r;
    logic       busy_r;
    logic       done_r;
    logic       err_r;

    logic       one_hot;
    logic       in_order;
    logic       legal;
    logic [4:0] sum;
    logic [8:0] shifted;

    assign one_hot  = (bus.T != 8'd0) && ((bus.T & (bus.T - 8'd1)) == 8'd0);
    // An empty tracker accepts any one-hot phase so the checker can resynchronise.
    assign in_order = !CHECK_ORDER || (prev_t == 8'd0) || (bus.T == {prev_t[6:0], prev_t[7]});
    assign legal    = one_hot && in_order;

    assign sum      = acc + (mplier[0] ? {1'b0, mcand} : 5'd0);
    assign shifted  = {sum, mplier} >> 1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            prev_t <= 8'd0;
            acc    <= 5'd0;
            mcand  <= 4'd0;
            mplier <= 4'd0;
            p_r    <= 8'd0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (bus.clr_err) begin
                err_r  <= 1'b0;
                prev_t <= 8'd0;
            end else if (!legal) begin
                err_r  <= 1'b1;
                state  <= IDLE;
                busy_r <= 1'b0;
                prev_t <= 8'd0;
            end else begin
                prev_t <= bus.T;
                if (bus.T[0]) begin
                    if (state == IDLE && bus.start && !err_r) begin
                        mcand  <= bus.a;
                        mplier <= bus.b;
                        acc    <= 5'd0;
                        state  <= RUN;
                        busy_r <= 1'b1;
                    end
                end else if (|bus.T[4:1]) begin
                    if (state == RUN) begin
                        {acc, mplier} <= shifted;
                    end
                end else if (bus.T[5]) begin
                    if (state == RUN) begin
                        p_r    <= {acc[3:0], mplier};
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
            end
        end
    end

    assign bus.p         = p_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.phase_err = err_r;
endmodule

// File: tb/tb_johnson_phase_multiplier.sv
// Directed and randomized checks of the Johnson-phase multiplier, with and without phase-order checking.
module tb_johnson_phase_multiplier;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] t;
    logic       start;
    logic       clr_err;
    logic [3:0] a;
    logic [3:0] b;

    int checks   = 0;
    int failures = 0;
    int ph       = 0;
    int dcount;

    always #5 clk = ~clk;

    johnson_phase_multiplier_if bus0 ();
    johnson_phase_multiplier_if bus1 ();

    assign bus0.T = t;  assign bus0.start = start;  assign bus0.a = a;  assign bus0.b = b;  assign bus0.clr_err = clr_err;
    assign bus1.T = t;  assign bus1.start = start;  assign bus1.a = a;  assign bus1.b = b;  assign bus1.clr_err = clr_err;

    johnson_phase_multiplier #(.CHECK_ORDER(1'b1)) u_ord   (.clk(clk), .reset(reset), .bus(bus0.slave));
    johnson_phase_multiplier #(.CHECK_ORDER(1'b0)) u_noord (.clk(clk), .reset(reset), .bus(bus1.slave));

    // Reference model: product taken as a*b at launch, delivered on the fifth phase of the revolution.
    bit         m_run  [2];
    bit         m_err  [2];
    bit         m_busy [2];
    bit         m_done [2];
    logic [7:0] m_prev [2];
    logic [7:0] m_p    [2];
    logic [7:0] m_prod [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_err[i] = 0; m_busy[i] = 0; m_done[i] = 0;
            m_prev[i] = 8'd0; m_p[i] = 8'd0; m_prod[i] = 8'd0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit         legal;
            logic [7:0] succ;
            succ  = 8'((m_prev[i] << 1) | (m_prev[i] >> 7));
            legal = ($countones(t) == 1) && ((i == 1) || m_prev[i] == 8'd0 || t == succ);
            m_done[i] = 0;
            if (clr_err) begin
                m_err[i]  = 0;
                m_prev[i] = 8'd0;
            end else if (!legal) begin
                m_err[i]  = 1;
                m_run[i]  = 0;
                m_busy[i] = 0;
                m_prev[i] = 8'd0;
            end else begin
                m_prev[i] = t;
                if (t == 8'h01 && !m_run[i] && start && !m_err[i]) begin
                    m_run[i]  = 1;
                    m_busy[i] = 1;
                    m_prod[i] = 8'(int'(a) * int'(b));
                end else if (t == 8'h20 && m_run[i]) begin
                    m_p[i]    = m_prod[i];
                    m_done[i] = 1;
                    m_busy[i] = 0;
                    m_run[i]  = 0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("ord.p",         32'(bus0.p),         32'(m_p[0]));
        chk("ord.busy",      32'(bus0.busy),      32'(m_busy[0]));
        chk("ord.done",      32'(bus0.done),      32'(m_done[0]));
        chk("ord.phase_err", 32'(bus0.phase_err), 32'(m_err[0]));
        chk("any.p",         32'(bus1.p),         32'(m_p[1]));
        chk("any.busy",      32'(bus1.busy),      32'(m_busy[1]));
        chk("any.done",      32'(bus1.done),      32'(m_done[1]));
        chk("any.phase_err", 32'(bus1.phase_err), 32'(m_err[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else       model_step();
        #1;
        chk_all();
    endtask

    task automatic step_phase();
        t = 8'd1 << ph;
        tick();
        ph = (ph + 1) % 8;
    endtask

    initial begin
        reset = 1'b1; t = 8'd0; start = 1'b0; clr_err = 1'b0; a = 4'd0; b = 4'd0;
        model_reset();
        #2;
        tick();
        tick();
        chk("rst.p", 32'(bus0.p), 32'd0);
        chk("rst.busy", 32'(bus0.busy), 32'd0);
        reset = 1'b0;

        // 13 x 11 on a clean stream
        ph = 0; a = 4'd13; b = 4'd11; start = 1'b1;
        step_phase();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step_phase();
            chk("13x11.busy", 32'(bus0.busy), 32'd1);
        end
        step_phase();
        chk("13x11.p", 32'(bus0.p), 32'd143);
        chk("13x11.done", 32'(bus0.done), 32'd1);
        step_phase();
        chk("13x11.done_once", 32'(bus0.done), 32'd0);
        step_phase();

        // 15 x 15
        a = 4'd15; b = 4'd15; start = 1'b1;
        step_phase();
        start = 1'b0;
        for (int k = 1; k < 8; k++) step_phase();
        chk("15x15.p", 32'(bus0.p), 32'd225);

        // 0 x 9 with start held across two revolutions
        a = 4'd0; b = 4'd9; start = 1'b1; dcount = 0;
        for (int k = 0; k < 16; k++) begin
            if (k == 4) chk("b2b.old_p", 32'(bus0.p), 32'd225);
            step_phase();
            dcount += int'(bus0.done);
        end
        start = 1'b0;
        chk("b2b.p", 32'(bus0.p), 32'd0);
        chk("b2b.dones", 32'(dcount), 32'd2);

        // start raised in T[3] waits for the next T[0]
        a = 4'd6; b = 4'd7;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) start = 1'b1;
            step_phase();
            chk("late.idle_busy", 32'(bus0.busy), 32'd0);
        end
        step_phase();
        start = 1'b0;
        for (int k = 0; k < 5; k++) step_phase();
        chk("late.p", 32'(bus0.p), 32'd42);
        chk("late.done", 32'(bus0.done), 32'd1);
        step_phase(); step_phase();

        // non-one-hot phase in RUN aborts, error blocks start until cleared
        a = 4'd7; b = 4'd6; start = 1'b1;
        step_phase();
        start = 1'b0;
        step_phase();
        t = 8'b0000_0011;
        tick();
        ph = 3;
        chk("glitch.err", 32'(bus0.phase_err), 32'd1);
        chk("glitch.busy", 32'(bus0.busy), 32'd0);
        chk("glitch.p", 32'(bus0.p), 32'd42);
        for (int k = 3; k < 8; k++) step_phase();
        start = 1'b1;
        step_phase();
        start = 1'b0;
        chk("glitch.start_ignored", 32'(bus0.busy), 32'd0);
        clr_err = 1'b1;
        step_phase();
        clr_err = 1'b0;
        chk("clr.err", 32'(bus0.phase_err), 32'd0);
        for (int k = 2; k < 8; k++) step_phase();
        a = 4'd5; b = 4'd9; start = 1'b1;
        step_phase();
        start = 1'b0;
        for (int k = 1; k < 6; k++) step_phase();
        chk("clr.p", 32'(bus0.p), 32'd45);
        step_phase(); step_phase(); step_phase();

        // T[1] followed by T[3]: ordering error only where it is checked
        t = 8'h02; tick();
        t = 8'h08; tick();
        chk("order.ord_err", 32'(bus0.phase_err), 32'd1);
        chk("order.any_err", 32'(bus1.phase_err), 32'd0);
        clr_err = 1'b1;
        t = 8'h10; tick();
        clr_err = 1'b0;
        ph = 5;
        for (int k = 5; k < 8; k++) step_phase();

        // randomized revolutions with occasional glitches and error clears
        for (int r = 0; r < 60; r++) begin
            for (int k = 0; k < 8; k++) begin
                start   = 1'($urandom_range(0, 1));
                a       = 4'($urandom_range(0, 15));
                b       = 4'($urandom_range(0, 15));
                clr_err = (k == 6) && ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 24) == 0) begin
                    case ($urandom_range(0, 3))
                        0:       t = 8'h00;
                        1:       t = 8'h03;
                        2:       t = 8'hff;
                        default: t = 8'h81;
                    endcase
                    tick();
                    ph = (ph + 1) % 8;
                end else begin
                    step_phase();
                end
            end
        end
        start = 1'b0; clr_err = 1'b1;
        step_phase();
        clr_err = 1'b0;
        while (ph != 0) step_phase();

        // asynchronous reset between the T[3] and T[4] edges
        a = 4'd12; b = 4'd10; start = 1'b1;
        step_phase();
        start = 1'b0;
        for (int k = 1; k < 4; k++) step_phase();
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        chk_all();
        chk("arst.busy", 32'(bus0.busy), 32'd0);
        tick();
        reset = 1'b0;
        ph = 0; a = 4'd9; b = 4'd14; start = 1'b1;
        step_phase();
        start = 1'b0;
        for (int k = 1; k < 6; k++) step_phase();
        chk("arst.p", 32'(bus0.p), 32'd126);
        step_phase(); step_phase();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
